// File: rtl/expr_sweep_eval.sv
// NOR/NAND expression evaluator (Y = NOR(upper half) & NAND(lower half)) with a
// truth-table sweeper FSM and an independent registered path for external vectors.
module expr_sweep_eval #(
    parameter int NIN   = 4,
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [NIN-1:0]    vec,
    output logic              y,
    output logic [2**NIN-1:0] tt,
    output logic [NIN:0]      ones,
    input  logic              ext_valid,
    input  logic [NIN-1:0]    ext_vec,
    output logic              ext_y_valid,
    output logic              ext_y
);

    localparam int NVEC = 2**NIN;
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [NIN-1:0]  VEC_LAST = '1;
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic expr_f(input logic [NIN-1:0] v);
        return ~|v[NIN-1:NIN/2] & ~&v[NIN/2-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [NIN-1:0]    vec_q, vec_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [NVEC-1:0]   tt_q, tt_d;
    logic [NIN:0]      ones_q, ones_d;
    logic              ext_y_valid_q;
    logic              ext_y_q;

    assign y = expr_f(vec_q);

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        tt_d    = tt_q;
        ones_d  = ones_q;

        if (abort) begin
            state_d = IDLE;
            vec_d   = '0;
            dwell_d = '0;
            tt_d    = '0;
            ones_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = SWEEP;
                        vec_d   = '0;
                        dwell_d = '0;
                        tt_d    = '0;
                        ones_d  = '0;
                    end
                end
                SWEEP: begin
                    dwell_d = dwell_q + DW_W'(1);
                    // The last dwell cycle of a vector records its result and moves on.
                    if (dwell_q == DW_LAST) begin
                        dwell_d     = '0;
                        tt_d[vec_q] = y;
                        ones_d      = ones_q + {{NIN{1'b0}}, y};
                        if (vec_q == VEC_LAST) begin
                            state_d = DONE;
                        end else begin
                            vec_d = vec_q + NIN'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            dwell_q <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

    // External vectors are evaluated independently of the sweeper; result holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_y_valid_q <= 1'b0;
            ext_y_q       <= 1'b0;
        end else begin
            ext_y_valid_q <= ext_valid;
            if (ext_valid) begin
                ext_y_q <= expr_f(ext_vec);
            end
        end
    end

    assign busy        = (state_q == SWEEP);
    assign done        = (state_q == DONE);
    assign vec         = vec_q;
    assign tt          = tt_q;
    assign ones        = ones_q;
    assign ext_y_valid = ext_y_valid_q;
    assign ext_y       = ext_y_q;

endmodule

// File: tb/tb_expr_sweep_eval.sv
// Scoreboard bench for expr_sweep_eval: four instances (4/1, 4/10, 6/1, 2/1) checked
// by a negedge monitor that pops expected sweep and external-path results.
module tb_expr_sweep_eval;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_s [4];
    logic abort_s [4];
    logic ext_valid;
    logic [3:0] ext_vec;

    // Instance a: NIN=4, DWELL=1
    logic        busy_a, done_a, y_a, eyv_a, ey_a;
    logic [3:0]  vec_a;
    logic [15:0] tt_a;
    logic [4:0]  ones_a;
    // Instance b: NIN=4, DWELL=10
    logic        busy_b, done_b, y_b, eyv_b, ey_b;
    logic [3:0]  vec_b;
    logic [15:0] tt_b;
    logic [4:0]  ones_b;
    // Instance c: NIN=6, DWELL=1
    logic        busy_c, done_c, y_c, eyv_c, ey_c;
    logic [5:0]  vec_c;
    logic [63:0] tt_c;
    logic [6:0]  ones_c;
    // Instance d: NIN=2, DWELL=1
    logic        busy_d, done_d, y_d, eyv_d, ey_d;
    logic [1:0]  vec_d;
    logic [3:0]  tt_d;
    logic [2:0]  ones_d;

    expr_sweep_eval #(.NIN(4), .DWELL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .busy(busy_a), .done(done_a), .vec(vec_a), .y(y_a), .tt(tt_a), .ones(ones_a),
        .ext_valid(ext_valid), .ext_vec(ext_vec), .ext_y_valid(eyv_a), .ext_y(ey_a));
    expr_sweep_eval #(.NIN(4), .DWELL(10)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .busy(busy_b), .done(done_b), .vec(vec_b), .y(y_b), .tt(tt_b), .ones(ones_b),
        .ext_valid(1'b0), .ext_vec(4'd0), .ext_y_valid(eyv_b), .ext_y(ey_b));
    expr_sweep_eval #(.NIN(6), .DWELL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
        .busy(busy_c), .done(done_c), .vec(vec_c), .y(y_c), .tt(tt_c), .ones(ones_c),
        .ext_valid(1'b0), .ext_vec(6'd0), .ext_y_valid(eyv_c), .ext_y(ey_c));
    expr_sweep_eval #(.NIN(2), .DWELL(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_s[3]), .abort(abort_s[3]),
        .busy(busy_d), .done(done_d), .vec(vec_d), .y(y_d), .tt(tt_d), .ones(ones_d),
        .ext_valid(1'b0), .ext_vec(2'd0), .ext_y_valid(eyv_d), .ext_y(ey_d));

    logic        busy_w [4];
    logic        done_w [4];
    logic [63:0] tt_w   [4];
    logic [63:0] ones_w [4];
    assign busy_w[0] = busy_a;  assign done_w[0] = done_a;
    assign busy_w[1] = busy_b;  assign done_w[1] = done_b;
    assign busy_w[2] = busy_c;  assign done_w[2] = done_c;
    assign busy_w[3] = busy_d;  assign done_w[3] = done_d;
    assign tt_w[0] = 64'(tt_a);     assign ones_w[0] = 64'(ones_a);
    assign tt_w[1] = 64'(tt_b);     assign ones_w[1] = 64'(ones_b);
    assign tt_w[2] = tt_c;          assign ones_w[2] = 64'(ones_c);
    assign tt_w[3] = 64'(tt_d);     assign ones_w[3] = 64'(ones_d);

    typedef struct {
        int          id;
        logic [63:0] tt;
        int          ones;
        int          lat;
    } sweep_exp_t;

    sweep_exp_t sweep_q[$];
    bit         ext_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares sweep results on each rising done and ext results on ext_y_valid.
    int   busy_cnt  [4];
    logic busy_prev [4];
    logic done_prev [4];
    initial for (int k = 0; k < 4; k++) begin
        busy_cnt[k] = 0; busy_prev[k] = 1'b0; done_prev[k] = 1'b0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (busy_w[k] && !busy_prev[k]) busy_cnt[k] = 1;
            else if (busy_w[k])             busy_cnt[k]++;
            if (done_w[k] && !done_prev[k]) begin
                if (sweep_q.size() == 0) begin
                    check($sformatf("sweep%0d_unexpected_done", k), 64'(done_w[k]), 64'd0);
                end else begin
                    sweep_exp_t e;
                    e = sweep_q.pop_front();
                    check($sformatf("sweep%0d_id", k), 64'(k), 64'(e.id));
                    check($sformatf("sweep%0d_tt", k), tt_w[k], e.tt);
                    check($sformatf("sweep%0d_ones", k), ones_w[k], 64'(e.ones));
                    check($sformatf("sweep%0d_latency", k), 64'(busy_cnt[k]), 64'(e.lat));
                end
            end
            busy_prev[k] = busy_w[k];
            done_prev[k] = done_w[k];
        end
        if (eyv_a) begin
            if (ext_q.size() == 0) begin
                check("ext_unexpected_valid", 64'(eyv_a), 64'd0);
            end else begin
                check("ext_y", 64'(ey_a), 64'(ext_q.pop_front()));
            end
        end
    end

    task automatic push_sweep(input int id, input logic [63:0] tt, input int ones, input int lat);
        sweep_exp_t e;
        e.id = id; e.tt = tt; e.ones = ones; e.lat = lat;
        sweep_q.push_back(e);
    endtask

    task automatic pulse_start(input int k);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (!done_w[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done%0d_seen", k), 64'(done_w[k]), 64'd1);
    endtask

    task automatic wait_vec_a(input logic [3:0] target);
        int n = 0;
        while (vec_a != target && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("vec_a_reached", 64'(vec_a), 64'(target));
    endtask

    task automatic drive_ext(input logic [3:0] v, input bit exp);
        ext_valid = 1'b1;
        ext_vec   = v;
        ext_q.push_back(exp);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
        end
        ext_valid = 1'b0;
        ext_vec   = 4'd0;
        rst_n     = 1'b0;
        #3;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_vec", 64'(vec_a), 64'd0);
        check("rst_y", 64'(y_a), 64'd1);
        check("rst_tt", 64'(tt_a), 64'd0);
        check("rst_ones", 64'(ones_a), 64'd0);
        check("rst_ext_y_valid", 64'(eyv_a), 64'd0);
        check("rst_ext_y", 64'(ey_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // External path with the sweeper idle.
        drive_ext(4'd0, 1'b1);
        drive_ext(4'd3, 1'b0);
        drive_ext(4'd4, 1'b0);
        drive_ext(4'd12, 1'b0);
        ext_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Test 1: full sweep NIN=4 DWELL=1, with external traffic during the sweep.
        push_sweep(0, 64'h0007, 3, 16);
        pulse_start(0);
        check("t1_busy", 64'(busy_a), 64'd1);
        drive_ext(4'd12, 1'b0);
        drive_ext(4'd3, 1'b0);
        drive_ext(4'd0, 1'b1);
        drive_ext(4'd1, 1'b1);
        ext_valid = 1'b0;
        ext_vec   = 4'd3;
        @(negedge clk);
        @(negedge clk);
        check("ext_hold_y", 64'(ey_a), 64'd1);
        check("ext_hold_valid", 64'(eyv_a), 64'd0);
        wait_done(0, 40);
        @(negedge clk);
        check("t1_done_level", 64'(done_a), 64'd1);
        check("t1_tt_hold", 64'(tt_a), 64'h0007);

        // Test 2: NIN=4 DWELL=10, vec advances every 10 clocks.
        push_sweep(1, 64'h0007, 3, 160);
        pulse_start(1);
        for (int i = 0; i < 160; i++) begin
            if ((i % 10) == 0 || (i % 10) == 9)
                check($sformatf("t2_vec_at_%0d", i), 64'(vec_b), 64'(i / 10));
            @(negedge clk);
        end
        check("t2_done_at_160", 64'(done_b), 64'd1);

        // Test 3: other widths.
        push_sweep(2, 64'h7F, 7, 64);
        pulse_start(2);
        wait_done(2, 80);
        push_sweep(3, 64'h1, 1, 4);
        pulse_start(3);
        wait_done(3, 20);

        // Test 4: abort mid-sweep, then abort beats start, then start ignored in SWEEP.
        pulse_start(0);
        wait_vec_a(4'd5);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("t4_abort_busy", 64'(busy_a), 64'd0);
        check("t4_abort_vec", 64'(vec_a), 64'd0);
        check("t4_abort_tt", 64'(tt_a), 64'd0);
        check("t4_abort_ones", 64'(ones_a), 64'd0);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check("t4_prio_busy", 64'(busy_a), 64'd0);
        check("t4_prio_done", 64'(done_a), 64'd0);
        @(negedge clk);
        check("t4_idle_stays", 64'(busy_a), 64'd0);
        push_sweep(0, 64'h0007, 3, 16);
        pulse_start(0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        wait_done(0, 40);

        // Test 6: asynchronous reset mid-sweep, then a clean sweep.
        pulse_start(0);
        wait_vec_a(4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy_a), 64'd0);
        check("t6_done", 64'(done_a), 64'd0);
        check("t6_vec", 64'(vec_a), 64'd0);
        check("t6_y", 64'(y_a), 64'd1);
        check("t6_tt", 64'(tt_a), 64'd0);
        check("t6_ones", 64'(ones_a), 64'd0);
        check("t6_ext_y", 64'(ey_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_sweep(0, 64'h0007, 3, 16);
        pulse_start(0);
        wait_done(0, 40);

        repeat (3) @(negedge clk);
        check("sweep_queue_empty", 64'(sweep_q.size()), 64'd0);
        check("ext_queue_empty", 64'(ext_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
